irrigation_scheduler: RTL and testbench
=======================================

# irrigation_scheduler

Sequencer and arbiter for the shared tank outlet of the irrigation controller. It accepts sprinkler (asp), drip (got) and fertilizer (adb) requests and grants the single outlet to one irrigation mode at a time. It refills the tank when the level is too low, forces a cleaning flush after every fertilized cycle, and locks out on error. It sits between the user switches/level sensor and the valve/display logic, timed by the divided `tick` from the clock-divider chain.

## Interface
Parameters:
- `TW`, 8, width of the tick timer.
- `SPRINK_TICKS`, 20, sprinkler cycle length in ticks (≥1).
- `DRIP_TICKS`, 40, drip cycle length in ticks (≥1).
- `CLEAN_TICKS`, 10, post-fertilizer flush length in ticks (≥1).
- `FILL_TICKS`, 60, fill timeout in ticks (used only with the macro in Configuration).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-`clock`-wide timer enable from the divider.
- `req_asp`  in  1  sprinkler request, level-sensitive.
- `req_got`  in  1  drip request, level-sensitive.
- `req_adb`  in  1  fertilizer request, latched sticky.
- `level`  in  3  thermometer tank level: 000 empty, 001 low, 011 mid, 111 full.
- `err_in`  in  1  external error.
- `grant_asp`  out  1  sprinkler valve open.
- `grant_got`  out  1  drip valve open.
- `adb_inject`  out  1  fertilizer pump on.
- `valve_fill`  out  1  inlet valve open.
- `clean_active`  out  1  flush in progress.
- `fault`  out  1  lockout.
- `state_o`  out  3  state code for the display.

## Operation
- Moore FSM with states IDLE=0, FILL=1, SPRINKLE=2, DRIP=3, CLEAN=4, FAULT=5. All outputs are decoded from the state register plus the `fert` flag.
- Output mapping: `grant_asp` in SPRINKLE; `grant_got` in DRIP; `valve_fill` in FILL and CLEAN; `clean_active` in CLEAN; `adb_inject` in SPRINKLE only when `fert`=1; `fault` in FAULT.
- `adb_pend` sets on `req_adb`=1 and clears when consumed at SPRINKLE entry. Entering SPRINKLE copies `adb_pend` into `fert`.
- IDLE with no request: stay.
- IDLE with any request and `level`<011: go to FILL.
- IDLE with any request and `level`≥011: arbitrate.
  - Single requester wins.
  - If both request, round-robin: the one not served last wins. `last` resets to got, so asp wins first.
- FILL exits to IDLE when `level`=111. Requests are re-arbitrated there.
- SPRINKLE and DRIP end after their tick count.
  - SPRINKLE with `fert`=1 goes to CLEAN; otherwise go to IDLE.
  - DRIP goes to IDLE. `adb_pend` is not consumed by drip.
- `level`=000 during SPRINKLE or DRIP aborts to FILL. The timer clears, `last` is not updated, and the request is still served later.
  - An aborted fertilized sprinkle goes to CLEAN first, then IDLE.
- CLEAN ends after `CLEAN_TICKS` and goes to IDLE, clearing `fert`.
- `err_in`=1 in any state, or a non-thermometer `level` (010, 100, 101, 110), forces FAULT. FAULT exits only by reset.
- A request dropped mid-cycle does not shorten the cycle.

## Timing
- Reset values: state IDLE, `last`=got, `adb_pend`=0, `fert`=0, timer 0. Every output is 0 and `state_o`=0.
- Decision at clock edge N gives new outputs valid after edge N; the grant follows the request by 1 clock.
- The timer clears on state entry and increments on `tick`. The state leaves on the edge where `tick`=1 and timer=`*_TICKS`-1. A cycle therefore spans exactly `*_TICKS` tick pulses.
- Priority on the same edge: FAULT > level abort > timer expiry > arbitration.
- Reset asserted mid-cycle closes all valves immediately (asynchronous).

## Configuration
- `IRR_SCHED_FILL_TIMEOUT_EN` defined: FILL lasting `FILL_TICKS` ticks without reaching 111 goes to FAULT.
- `IRR_SCHED_FILL_TIMEOUT_EN` undefined: FILL waits indefinitely, and `FILL_TICKS` is unused.

## Structure
- Package `irrigation_pkg` holds the state enum and encodings, the level constants (L_EMPTY, L_LOW, L_MID, L_FULL), and the default tick counts.
- Sub-module `tick_timer` is a `TW`-bit counter with clear, `tick` enable and a terminal-count compare output. There is one instance, shared by all timed states.

## Test plan
- Reset, then `level`=111 and `req_asp` pulse: `grant_asp` is high 1 clock later for exactly 20 ticks, then the block returns to IDLE.
- `req_asp`=`req_got`=1 held with `level`=111: SPRINKLE(20), then DRIP(40), then SPRINKLE, alternating.
- `req_adb` pulse, then `req_asp`: SPRINKLE with `adb_inject`=1, then CLEAN for 10 ticks with `valve_fill`=1, then IDLE with `adb_pend`=0.
- `req_got` with `level`=001: FILL with `valve_fill`=1; at `level`=111, IDLE then DRIP. Dropping to 000 mid-DRIP aborts to FILL.
- `err_in` pulse during DRIP: next clock FAULT with all valves 0. `level`=101 behaves the same. Only reset leaves FAULT.
- With the macro and `level` stuck at 011 in FILL: `fault`=1 after 60 ticks. Without the macro: FILL persists.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared types and constants for the irrigation tank-outlet scheduler.
package irrigation_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_SPRINKLE = 3'd2,
    S_DRIP     = 3'd3,
    S_CLEAN    = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  localparam logic [2:0] L_EMPTY = 3'b000;
  localparam logic [2:0] L_LOW   = 3'b001;
  localparam logic [2:0] L_MID   = 3'b011;
  localparam logic [2:0] L_FULL  = 3'b111;

  localparam int DEF_TW           = 8;
  localparam int DEF_SPRINK_TICKS = 20;
  localparam int DEF_DRIP_TICKS   = 40;
  localparam int DEF_CLEAN_TICKS  = 10;
  localparam int DEF_FILL_TICKS   = 60;

  // Only thermometer codes are legal sensor readings.
  function automatic logic level_valid(input logic [2:0] l);
    return (l == L_EMPTY) || (l == L_LOW) || (l == L_MID) || (l == L_FULL);
  endfunction

endpackage

// File: rtl/irrigation_scheduler_tick_timer.sv
// Tick counter shared by all timed states; expire fires on the tick that completes the limit.
module tick_timer #(
  parameter int TW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          tick,
  input  logic [TW-1:0] limit,
  output logic          expire
);

  logic [TW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      count <= '0;
    else if (clear)  count <= '0;
    else if (tick)   count <= count + 1'b1;
  end

  assign expire = tick && (count == limit - 1'b1);

endmodule

// File: rtl/irrigation_scheduler.sv
// Tank-outlet sequencer/arbiter: sprinkle, drip, fertilizer flush, refill and error lockout.
// Optional macro IRR_SCHED_FILL_TIMEOUT_EN: a FILL that never reaches full locks out after FILL_TICKS.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int TW           = DEF_TW,
  parameter int SPRINK_TICKS = DEF_SPRINK_TICKS,
  parameter int DRIP_TICKS   = DEF_DRIP_TICKS,
  parameter int CLEAN_TICKS  = DEF_CLEAN_TICKS,
  parameter int FILL_TICKS   = DEF_FILL_TICKS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       req_asp,
  input  logic       req_got,
  input  logic       req_adb,
  input  logic [2:0] level,
  input  logic       err_in,
  output logic       grant_asp,
  output logic       grant_got,
  output logic       adb_inject,
  output logic       valve_fill,
  output logic       clean_active,
  output logic       fault,
  output logic [2:0] state_o
);

  state_t        state, state_next;
  logic          last_asp;            // 1: sprinkler was served last, 0: drip
  logic          adb_pend, fert;
  logic          expire, enter_spr;
  logic          set_last_asp, set_last_got;
  logic [TW-1:0] limit;

  always_comb begin
    limit = TW'(FILL_TICKS);
    case (state)
      S_SPRINKLE: limit = TW'(SPRINK_TICKS);
      S_DRIP:     limit = TW'(DRIP_TICKS);
      S_CLEAN:    limit = TW'(CLEAN_TICKS);
      default:    limit = TW'(FILL_TICKS);
    endcase
  end

  tick_timer #(.TW(TW)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_next != state),
    .tick   (tick),
    .limit  (limit),
    .expire (expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Priority: fault > level abort > timer expiry > arbitration.
  always_comb begin
    state_next   = state;
    set_last_asp = 1'b0;
    set_last_got = 1'b0;
    if (err_in || !level_valid(level)) begin
      state_next = S_FAULT;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_asp || req_got) begin
            if (level == L_EMPTY || level == L_LOW)        state_next = S_FILL;
            else if (req_asp && (!req_got || !last_asp))  state_next = S_SPRINKLE;
            else                                           state_next = S_DRIP;
          end
        end
        S_FILL: begin
          if (level == L_FULL) state_next = S_IDLE;
`ifdef IRR_SCHED_FILL_TIMEOUT_EN
          else if (expire)     state_next = S_FAULT;
`endif
        end
        S_SPRINKLE: begin
          if (level == L_EMPTY) begin
            state_next = fert ? S_CLEAN : S_FILL;
          end else if (expire) begin
            state_next   = fert ? S_CLEAN : S_IDLE;
            set_last_asp = 1'b1;
          end
        end
        S_DRIP: begin
          if (level == L_EMPTY) begin
            state_next = S_FILL;
          end else if (expire) begin
            state_next   = S_IDLE;
            set_last_got = 1'b1;
          end
        end
        S_CLEAN:  if (expire) state_next = S_IDLE;
        S_FAULT:  state_next = S_FAULT;
        default:  state_next = S_FAULT;
      endcase
    end
  end

  assign enter_spr = (state_next == S_SPRINKLE) && (state != S_SPRINKLE);

  // A fertilizer request arriving on the consuming edge stays pending for the next sprinkle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_asp <= 1'b0;
      adb_pend <= 1'b0;
      fert     <= 1'b0;
    end else begin
      if (set_last_asp)      last_asp <= 1'b1;
      else if (set_last_got) last_asp <= 1'b0;
      adb_pend <= enter_spr ? req_adb : (adb_pend | req_adb);
      if (enter_spr)                                   fert <= adb_pend;
      else if (state == S_CLEAN && state_next == S_IDLE) fert <= 1'b0;
    end
  end

  always_comb begin
    grant_asp    = (state == S_SPRINKLE);
    grant_got    = (state == S_DRIP);
    adb_inject   = (state == S_SPRINKLE) && fert;
    valve_fill   = (state == S_FILL) || (state == S_CLEAN);
    clean_active = (state == S_CLEAN);
    fault        = (state == S_FAULT);
    state_o      = state;
  end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler; tick pulses once every 4 clocks.
module tb_irrigation_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       req_asp = 1'b0, req_got = 1'b0, req_adb = 1'b0, err_in = 1'b0;
  logic [2:0] level = 3'b111;
  logic       grant_asp, grant_got, adb_inject, valve_fill, clean_active, fault;
  logic [2:0] state_o;

  int vectors = 0;
  int miscompares = 0;
  int spr_t = 0, drp_t = 0, cln_t = 0;
  int tcnt = 0;
  int s0, d0, c0;

  irrigation_scheduler dut (
    .clock(clock), .reset(reset), .tick(tick),
    .req_asp(req_asp), .req_got(req_got), .req_adb(req_adb),
    .level(level), .err_in(err_in),
    .grant_asp(grant_asp), .grant_got(grant_got), .adb_inject(adb_inject),
    .valve_fill(valve_fill), .clean_active(clean_active), .fault(fault),
    .state_o(state_o)
  );

  always #5 clock = ~clock;

  initial begin
    forever begin
      @(negedge clock);
      tick = (tcnt % 4 == 3);
      tcnt++;
    end
  end

  // Ticks consumed per timed state, counted on the edges that state saw.
  always @(posedge clock) begin
    if (tick && state_o == 3'd2) spr_t++;
    if (tick && state_o == 3'd3) drp_t++;
    if (tick && state_o == 3'd4) cln_t++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_state(input logic [2:0] exp, input int budget, input string tag);
    for (int i = 0; i < budget && state_o !== exp; i++) @(negedge clock);
    check(tag, state_o, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req_asp = 0; req_got = 0; req_adb = 0; err_in = 0; level = 3'b111;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic pulse_asp();
    req_asp = 1'b1; @(negedge clock); req_asp = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_state", state_o, 0);
    check("rst_outs", {grant_asp, grant_got, adb_inject, valve_fill, clean_active, fault}, 0);

    // Single sprinkle request
    pulse_asp();
    check("spr_grant", grant_asp, 1);
    check("spr_state", state_o, 2);
    s0 = spr_t;
    wait_state(3'd0, 200, "spr_done");
    check("spr_ticks", spr_t - s0, 20);
    check("spr_closed", grant_asp, 0);

    // Both requesting after reset: asp first, then alternate
    do_reset();
    req_asp = 1; req_got = 1;
    clk(1);
    check("rr_first_asp", state_o, 2);
    s0 = spr_t;
    wait_state(3'd3, 200, "rr_then_drip");
    check("rr_spr_ticks", spr_t - s0, 20);
    check("rr_drip_grant", grant_got, 1);
    d0 = drp_t;
    wait_state(3'd2, 400, "rr_then_spr");
    check("rr_drip_ticks", drp_t - d0, 40);
    s0 = spr_t;
    clk(3);
    req_asp = 0; req_got = 0;
    wait_state(3'd0, 200, "rr_drop_idle");
    check("rr_drop_full_len", spr_t - s0, 20);

    // Fertilized sprinkle then flush
    req_adb = 1; clk(1); req_adb = 0;
    check("adb_stay_idle", state_o, 0);
    pulse_asp();
    check("fert_inject", adb_inject, 1);
    wait_state(3'd4, 200, "fert_clean");
    check("clean_outs", {adb_inject, valve_fill, clean_active}, 3'b011);
    c0 = cln_t;
    wait_state(3'd0, 100, "clean_done");
    check("clean_ticks", cln_t - c0, 10);
    pulse_asp();
    check("pend_cleared", {grant_asp, adb_inject}, 2'b10);
    wait_state(3'd0, 200, "plain_done");

    // Low level fill, then drip, then abort on empty
    level = 3'b001; req_got = 1;
    clk(1);
    check("fill_state", state_o, 1);
    check("fill_valve", valve_fill, 1);
    clk(5);
    level = 3'b111;
    clk(1);
    check("fill_to_idle", state_o, 0);
    clk(1);
    check("idle_to_drip", state_o, 3);
    clk(10);
    level = 3'b000;
    clk(1);
    check("drip_abort", state_o, 1);
    level = 3'b111;
    clk(2);
    check("drip_resumed", state_o, 3);
    req_got = 0;
    wait_state(3'd0, 400, "drip_done");

    // Aborted fertilized sprinkle flushes first
    req_adb = 1; clk(1); req_adb = 0;
    pulse_asp();
    clk(10);
    level = 3'b000;
    clk(1);
    check("fert_abort_clean", state_o, 4);
    level = 3'b111;
    wait_state(3'd0, 100, "fert_abort_idle");

    // Error pulse during drip
    req_got = 1; clk(3);
    err_in = 1; clk(1); err_in = 0; req_got = 0;
    check("err_fault", state_o, 5);
    check("err_outs", {grant_asp, grant_got, valve_fill, fault}, 4'b0001);
    clk(8);
    check("fault_sticky", fault, 1);
    do_reset();
    check("fault_reset", state_o, 0);

    // Non-thermometer level during drip
    req_got = 1; clk(3);
    level = 3'b101; clk(1);
    check("badlvl_fault", {grant_got, fault}, 2'b01);
    do_reset();

    // Asynchronous reset mid-sprinkle
    pulse_asp();
    clk(4);
    #2 reset = 1'b0;
    #1 check("async_rst", {grant_asp, state_o}, 0);
    @(negedge clock); reset = 1'b1;

    // Fill stuck at mid level
    level = 3'b001; req_got = 1; clk(1);
    level = 3'b011;
    clk(300);
`ifdef IRR_SCHED_FILL_TIMEOUT_EN
    check("fill_timeout", state_o, 5);
`else
    check("fill_persist", state_o, 1);
`endif
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
